// File: rtl/add_acc_n.sv
// add_acc_n: joins NUM_IN operand channels, sums one operand from each channel
// and accumulates ACC_LEN such joined sets into a single result.
//
// Each channel has a one-deep operand register. A set "fires" when every
// channel register holds an operand. On a firing the sum of the set is folded
// into the accumulator. On the ACC_LEN-th firing the final value goes to the
// output register instead.
//
// Handshake semantics:
// - Input side: add__in_rdy[i] is a combinational accept strobe.
// - It may depend on add__in_vld[i].
// - A transfer happens in any cycle where both add__in_vld[i] and
//   add__in_rdy[i] are high.
// - Output side: the result transfers when add__out0_vld and add__out0_rdy are
//   both high.
// - add__out0 and add__out0_ovf stay stable while add__out0_vld is high and
//   add__out0_rdy is low.
//
// Optional feature macro: ADD_ACC_SAT_EN.
// - Defined: the final result saturates to the signed WIDTH range and
//   add__out0_ovf flags each clamp.
// - Undefined: the result wraps to its low WIDTH bits and add__out0_ovf is
//   always 0.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous active-low reset
//   add__in       NUM_IN operands, channel i at [i*WIDTH +: WIDTH]
//   add__in_vld   per-channel operand valid
//   add__in_rdy   per-channel operand accept strobe
//   add__out0     result
//   add__out0_vld result valid
//   add__out0_rdy result consumer ready
//   add__out0_ovf result was clamped (qualified by add__out0_vld)
module add_acc_n #(
  parameter int WIDTH   = 32,
  parameter int NUM_IN  = 4,
  parameter int ACC_LEN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*WIDTH-1:0]  add__in,
  input  logic [NUM_IN-1:0]        add__in_vld,
  output logic [NUM_IN-1:0]        add__in_rdy,
  output logic [WIDTH-1:0]         add__out0,
  output logic                     add__out0_vld,
  input  logic                     add__out0_rdy,
  output logic                     add__out0_ovf
);

  // The accumulator is wide enough to hold NUM_IN*ACC_LEN signed operands
  // without any intermediate loss.
  localparam int AW = WIDTH + $clog2(NUM_IN * ACC_LEN) + 1;
  localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_LEN - 1);

`ifdef ADD_ACC_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

  logic [WIDTH-1:0]     op_q [NUM_IN];
  logic [WIDTH-1:0]     op_d [NUM_IN];
  logic [NUM_IN-1:0]    valid_q, valid_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ovf_q, ovf_d;

  logic [NUM_IN-1:0]    load_en;
  logic                 is_last, out_free, fire;
  logic signed [AW-1:0] sum, total;
  logic [WIDTH-1:0]     res;
  logic                 res_ovf;

  always_comb begin
    is_last  = (cnt_q == CNT_LAST);
    out_free = ~out_valid_q | add__out0_rdy;
    // Non-terminal firings only touch the accumulator, so they do not wait
    // for the output register to drain.
    fire     = (&valid_q) & (~is_last | out_free);

    sum = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sum = sum + {{(AW-WIDTH){op_q[i][WIDTH-1]}}, op_q[i]};
    end
    total = acc_q + sum;

`ifdef ADD_ACC_SAT_EN
    res     = total[WIDTH-1:0];
    res_ovf = 1'b0;
    if (total > SAT_MAX) begin
      res     = SAT_MAX[WIDTH-1:0];
      res_ovf = 1'b1;
    end else if (total < SAT_MIN) begin
      res     = SAT_MIN[WIDTH-1:0];
      res_ovf = 1'b1;
    end
`else
    res     = total[WIDTH-1:0];
    res_ovf = 1'b0;
`endif

    // A register may load when it is empty or is being consumed this cycle.
    // rst gates the strobe so nothing is accepted while reset is held.
    for (int i = 0; i < NUM_IN; i++) begin
      load_en[i] = add__in_vld[i] & (~valid_q[i] | fire) & rst;
      valid_d[i] = (~valid_q[i] | fire) ? add__in_vld[i] : valid_q[i];
      op_d[i]    = load_en[i] ? add__in[i*WIDTH +: WIDTH] : op_q[i];
    end

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q & ~add__out0_rdy;
    if (fire) begin
      if (!is_last) begin
        acc_d = total;
        cnt_d = cnt_q + 1'b1;
      end else begin
        // A terminal firing may coincide with a drain; the new result
        // replaces the old one, giving back-to-back results.
        out_d       = res;
        ovf_d       = res_ovf;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        op_q[i] <= '0;
      end
      valid_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        op_q[i] <= op_d[i];
      end
      valid_q     <= valid_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign add__in_rdy   = load_en;
  assign add__out0     = out_q;
  assign add__out0_vld = out_valid_q;
  assign add__out0_ovf = ovf_q;

endmodule

// File: tb/tb_add_acc_n.sv
// Bench for add_acc_n.
// - u_dut1: WIDTH=32, NUM_IN=4, ACC_LEN=1.
// - u_dut3: WIDTH=32, NUM_IN=4, ACC_LEN=3.
// Inputs are driven at the falling edge. Outputs are sampled 1 time unit
// later, well away from the rising edge.
module tb_add_acc_n;
  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] in1, in3;
  logic [N-1:0]   vld1, vld3, rdy1, rdy3;
  logic [W-1:0]   out1, out3;
  logic           ovld1, ovld3, ordy1, ordy3, ovf1, ovf3;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W:0] exp_q[$];   // {ovf, value} for u_dut1
  logic [W:0] exp3_q[$];  // {ovf, value} for u_dut3
  longint     ch1_q[N][$];
  longint     ch3_q[N][$];

  always #5 clk = ~clk;

  add_acc_n #(.WIDTH(W), .NUM_IN(N), .ACC_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .add__in(in1), .add__in_vld(vld1), .add__in_rdy(rdy1),
    .add__out0(out1), .add__out0_vld(ovld1), .add__out0_rdy(ordy1), .add__out0_ovf(ovf1)
  );

  add_acc_n #(.WIDTH(W), .NUM_IN(N), .ACC_LEN(3)) u_dut3 (
    .clk(clk), .rst(rst), .add__in(in3), .add__in_vld(vld3), .add__in_rdy(rdy3),
    .add__out0(out3), .add__out0_vld(ovld3), .add__out0_rdy(ordy3), .add__out0_ovf(ovf3)
  );

  // Reference result for an exact signed total.
  function automatic logic [W:0] model_res(input longint total);
`ifdef ADD_ACC_SAT_EN
    if (total > 64'sd2147483647)  return {1'b1, 32'h7fffffff};
    if (total < -64'sd2147483648) return {1'b1, 32'h80000000};
`endif
    return {1'b0, total[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h7fffffff;
      1:       return 32'h80000000;
      2:       return W'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  function automatic bit have_set(input bit dut3);
    for (int i = 0; i < N; i++) begin
      if ((dut3 ? ch3_q[i].size() : ch1_q[i].size()) == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    in1 = '0; in3 = '0; vld1 = '1; vld3 = '1; ordy1 = 1'b1; ordy3 = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_chk++; if (rdy1 !== 4'h0) begin n_fail++; $display("FAIL reset_rdy1: got %h expected 0", rdy1); end
    n_chk++; if (rdy3 !== 4'h0) begin n_fail++; $display("FAIL reset_rdy3: got %h expected 0", rdy3); end
    n_chk++; if ({ovld1, ovf1, out1} !== '0) begin n_fail++; $display("FAIL reset_out1: got vld=%b ovf=%b out=%h expected all 0", ovld1, ovf1, out1); end
    n_chk++; if ({ovld3, ovf3, out3} !== '0) begin n_fail++; $display("FAIL reset_out3: got vld=%b ovf=%b out=%h expected all 0", ovld3, ovf3, out3); end
    @(negedge clk);
    tick();
    n_chk++; if (rdy1 !== 4'h0 || ovld1 !== 1'b0) begin n_fail++; $display("FAIL reset_held: got rdy=%h vld=%b expected 0/0", rdy1, ovld1); end
    vld1 = '0; vld3 = '0;
    rst = 1'b1;
  endtask

  // Operands 1,2,3,4 in cycle 0 give a result of 10 in cycle 2.
  task automatic test_basic();
    ordy1 = 1'b1;
    in1 = {32'd4, 32'd3, 32'd2, 32'd1}; vld1 = '1;
    #1;
    n_chk++; if (rdy1 !== 4'hF) begin n_fail++; $display("FAIL basic_rdy: got %h expected f", rdy1); end
    tick(); vld1 = '0;
    n_chk++; if (ovld1 !== 1'b0) begin n_fail++; $display("FAIL basic_early: got vld=%b expected 0 in cycle 1", ovld1); end
    tick();
    n_chk++; if (ovld1 !== 1'b1 || out1 !== 32'd10 || ovf1 !== 1'b0) begin n_fail++; $display("FAIL basic_out: got vld=%b out=%0d ovf=%b expected 1/10/0", ovld1, out1, ovf1); end
    tick();
    n_chk++; if (ovld1 !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got vld=%b expected 0", ovld1); end
  endtask

  // Channels 0..2 arrive in cycle 0 and channel 3 in cycle 5.
  // The held operands must be used, not the later bus values.
  task automatic test_held();
    ordy1 = 1'b1;
    in1 = {32'd0, 32'd30, 32'd20, 32'd10}; vld1 = 4'b0111;
    #1;
    n_chk++; if (rdy1 !== 4'b0111) begin n_fail++; $display("FAIL held_rdy0: got %h expected 7", rdy1); end
    for (int c = 1; c <= 5; c++) begin
      tick();
      for (int i = 0; i < 3; i++) in1[i*W +: W] = $urandom();
      in1[3*W +: W] = 32'd40;
      vld1 = (c == 5) ? 4'b1111 : 4'b0111;
      #1;
      n_chk++; if (rdy1 !== ((c == 5) ? 4'b1000 : 4'b0000)) begin n_fail++; $display("FAIL held_rdy: cycle %0d got %h expected %h", c, rdy1, (c == 5) ? 4'b1000 : 4'b0000); end
      n_chk++; if (ovld1 !== 1'b0) begin n_fail++; $display("FAIL held_early: cycle %0d got vld=%b expected 0", c, ovld1); end
    end
    tick(); vld1 = '0;
    n_chk++; if (ovld1 !== 1'b0) begin n_fail++; $display("FAIL held_early: cycle 6 got vld=%b expected 0", ovld1); end
    tick();
    n_chk++; if (ovld1 !== 1'b1 || out1 !== 32'd100) begin n_fail++; $display("FAIL held_out: got vld=%b out=%0d expected 1/100", ovld1, out1); end
    tick();
  endtask

  // Eight sets on consecutive cycles must give eight results on consecutive
  // cycles. The first three sets hit the signed range limits.
  task automatic test_back_to_back();
    logic [W:0] e;
    longint     s;
    exp_q.delete();
    ordy1 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        case (c)
          0:       in1 = {32'd0, 32'd0, 32'h7fffffff, 32'h7fffffff};
          1:       in1 = {32'd0, 32'd0, 32'h80000000, 32'h80000000};
          2:       in1 = {32'd0, 32'd0, 32'd1, 32'h7fffffff};
          default: for (int i = 0; i < N; i++) in1[i*W +: W] = rand_op();
        endcase
        vld1 = '1;
        s = 0;
        for (int i = 0; i < N; i++) s += longint'($signed(in1[i*W +: W]));
        exp_q.push_back(model_res(s));
      end else begin
        vld1 = '0;
      end
      #1;
      if (c < 8) begin
        n_chk++; if (rdy1 !== 4'hF) begin n_fail++; $display("FAIL b2b_rdy: cycle %0d got %h expected f", c, rdy1); end
      end
      if (c >= 2) begin
        e = exp_q.pop_front();
        n_chk++; if (ovld1 !== 1'b1 || {ovf1, out1} !== e) begin n_fail++; $display("FAIL b2b_out: cycle %0d got vld=%b ovf=%b out=%h expected 1/%b/%h", c, ovld1, ovf1, out1, e[W], e[W-1:0]); end
      end
      tick();
    end
    n_chk++; if (ovld1 !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got vld=%b expected 0", ovld1); end
  endtask

  // Result A waits on a stalled consumer while set B sits in the operand
  // registers. Set C must be refused until the consumer resumes, and the
  // results must then arrive as A, B, C.
  task automatic test_backpressure();
    logic [W-1:0] a, b, c;
    a = $urandom(); b = $urandom(); c = $urandom();
    ordy1 = 1'b0;
    in1 = {a, 32'd0, 32'd0, 32'd0}; vld1 = '1;
    #1;
    n_chk++; if (rdy1 !== 4'hF) begin n_fail++; $display("FAIL bp_rdy_a: got %h expected f", rdy1); end
    tick();
    in1 = {32'd0, b, 32'd0, 32'd0};
    #1;
    n_chk++; if (rdy1 !== 4'hF) begin n_fail++; $display("FAIL bp_rdy_b: got %h expected f", rdy1); end
    tick();
    in1 = {32'd0, 32'd0, c, 32'd0};
    for (int k = 2; k < 5; k++) begin
      #1;
      n_chk++; if (rdy1 !== 4'h0) begin n_fail++; $display("FAIL bp_stall: cycle %0d got rdy=%h expected 0", k, rdy1); end
      n_chk++; if (ovld1 !== 1'b1 || out1 !== a) begin n_fail++; $display("FAIL bp_hold: cycle %0d got vld=%b out=%h expected 1/%h", k, ovld1, out1, a); end
      tick();
    end
    ordy1 = 1'b1;
    #1;
    n_chk++; if (rdy1 !== 4'hF) begin n_fail++; $display("FAIL bp_resume: got rdy=%h expected f", rdy1); end
    tick(); vld1 = '0;
    n_chk++; if (ovld1 !== 1'b1 || out1 !== b) begin n_fail++; $display("FAIL bp_out_b: got vld=%b out=%h expected 1/%h", ovld1, out1, b); end
    tick();
    n_chk++; if (ovld1 !== 1'b1 || out1 !== c) begin n_fail++; $display("FAIL bp_out_c: got vld=%b out=%h expected 1/%h", ovld1, out1, c); end
    tick();
    n_chk++; if (ovld1 !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got vld=%b expected 0", ovld1); end
  endtask

  // With ACC_LEN=3, three {1,1,1,1} sets give a single result of 12,
  // valid two cycles after the third set.
  task automatic test_accumulate();
    ordy3 = 1'b1;
    in3 = {32'd1, 32'd1, 32'd1, 32'd1};
    for (int c = 0; c < 3; c++) begin
      vld3 = '1;
      #1;
      n_chk++; if (rdy3 !== 4'hF) begin n_fail++; $display("FAIL acc_rdy: cycle %0d got %h expected f", c, rdy3); end
      n_chk++; if (ovld3 !== 1'b0) begin n_fail++; $display("FAIL acc_early: cycle %0d got vld=%b expected 0", c, ovld3); end
      tick();
    end
    vld3 = '0;
    n_chk++; if (ovld3 !== 1'b0) begin n_fail++; $display("FAIL acc_early: cycle 3 got vld=%b expected 0", ovld3); end
    tick();
    n_chk++; if (ovld3 !== 1'b1 || out3 !== 32'd12) begin n_fail++; $display("FAIL acc_out: got vld=%b out=%0d expected 1/12", ovld3, out3); end
    tick();
    n_chk++; if (ovld3 !== 1'b0) begin n_fail++; $display("FAIL acc_drain: got vld=%b expected 0", ovld3); end
  endtask

  // Random arrivals and back-pressure on both DUTs.
  // - Each channel's accepted operands queue up.
  // - The k-th operands of all channels form the k-th set.
  // - Results are grouped ACC_LEN sets at a time.
  task automatic test_random_stream();
    logic [W:0] e;
    longint     s, s3;
    int         g3;
    s3 = 0; g3 = 0;
    exp_q.delete(); exp3_q.delete();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        vld1[i] = ($urandom_range(0, 3) != 0); in1[i*W +: W] = rand_op();
        vld3[i] = ($urandom_range(0, 3) != 0); in3[i*W +: W] = rand_op();
      end
      ordy1 = ($urandom_range(0, 3) != 0);
      ordy3 = ($urandom_range(0, 3) != 0);
      #1;
      if (ovld1 && ordy1) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand1_extra: got unexpected result %h expected none", out1); end
        else begin
          e = exp_q.pop_front();
          if ({ovf1, out1} !== e) begin n_fail++; $display("FAIL rand1_out: got ovf=%b out=%h expected %b/%h", ovf1, out1, e[W], e[W-1:0]); end
        end
      end
      if (ovld3 && ordy3) begin
        n_chk++;
        if (exp3_q.size() == 0) begin n_fail++; $display("FAIL rand3_extra: got unexpected result %h expected none", out3); end
        else begin
          e = exp3_q.pop_front();
          if ({ovf3, out3} !== e) begin n_fail++; $display("FAIL rand3_out: got ovf=%b out=%h expected %b/%h", ovf3, out3, e[W], e[W-1:0]); end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (vld1[i] && rdy1[i]) ch1_q[i].push_back(longint'($signed(in1[i*W +: W])));
        if (vld3[i] && rdy3[i]) ch3_q[i].push_back(longint'($signed(in3[i*W +: W])));
      end
      while (have_set(1'b0)) begin
        s = 0;
        for (int i = 0; i < N; i++) s += ch1_q[i].pop_front();
        exp_q.push_back(model_res(s));
      end
      while (have_set(1'b1)) begin
        for (int i = 0; i < N; i++) s3 += ch3_q[i].pop_front();
        g3++;
        if (g3 == 3) begin
          exp3_q.push_back(model_res(s3));
          s3 = 0; g3 = 0;
        end
      end
      tick();
    end
    vld1 = '0; vld3 = '0; ordy1 = 1'b1; ordy3 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (ovld1) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand1_extra: got unexpected result %h expected none", out1); end
        else begin
          e = exp_q.pop_front();
          if ({ovf1, out1} !== e) begin n_fail++; $display("FAIL rand1_out: got ovf=%b out=%h expected %b/%h", ovf1, out1, e[W], e[W-1:0]); end
        end
      end
      if (ovld3) begin
        n_chk++;
        if (exp3_q.size() == 0) begin n_fail++; $display("FAIL rand3_extra: got unexpected result %h expected none", out3); end
        else begin
          e = exp3_q.pop_front();
          if ({ovf3, out3} !== e) begin n_fail++; $display("FAIL rand3_out: got ovf=%b out=%h expected %b/%h", ovf3, out3, e[W], e[W-1:0]); end
        end
      end
      tick();
    end
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand1_lost: got %0d results missing expected 0", exp_q.size()); end
    n_chk++; if (exp3_q.size() != 0) begin n_fail++; $display("FAIL rand3_lost: got %0d results missing expected 0", exp3_q.size()); end
  endtask

  // Reset in the middle of an accumulation.
  // - Start from a clean state and leave a result of 30 pending.
  // - Reach cnt=1 of the next group, then assert reset mid-cycle.
  // - All outputs must drop at once.
  // - The partial sum must be lost: the next group must give 6, not 26.
  task automatic test_reset_mid();
    vld1 = '0; vld3 = '0; ordy1 = 1'b1; ordy3 = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in3 = (c < 3) ? {32'd4, 32'd3, 32'd2, 32'd1} : {32'd5, 32'd5, 32'd5, 32'd5};
      vld3 = '1;
      #1;
      n_chk++; if (rdy3 !== 4'hF) begin n_fail++; $display("FAIL rmid_rdy: cycle %0d got %h expected f", c, rdy3); end
      tick();
    end
    vld3 = '0;
    tick();
    n_chk++; if (ovld3 !== 1'b1 || out3 !== 32'd30) begin n_fail++; $display("FAIL rmid_pre: got vld=%b out=%0d expected 1/30", ovld3, out3); end
    in3 = {32'd7, 32'd7, 32'd7, 32'd7}; vld3 = '1; vld1 = '1;
    #2 rst = 1'b0;
    #1;
    n_chk++; if ({ovld3, ovf3, out3} !== '0) begin n_fail++; $display("FAIL rmid_out3: got vld=%b ovf=%b out=%h expected all 0", ovld3, ovf3, out3); end
    n_chk++; if (rdy3 !== 4'h0 || rdy1 !== 4'h0) begin n_fail++; $display("FAIL rmid_rdy0: got rdy3=%h rdy1=%h expected 0/0", rdy3, rdy1); end
    @(negedge clk);
    vld1 = '0;
    rst = 1'b1;
    ordy3 = 1'b1;
    in3 = {32'd0, 32'd0, 32'd0, 32'd2};
    for (int c = 0; c < 3; c++) begin
      vld3 = '1;
      #1;
      n_chk++; if (rdy3 !== 4'hF) begin n_fail++; $display("FAIL rmid_rdy: post-reset cycle %0d got %h expected f", c, rdy3); end
      tick();
    end
    vld3 = '0;
    tick();
    n_chk++; if (ovld3 !== 1'b1 || out3 !== 32'd6) begin n_fail++; $display("FAIL rmid_out: got vld=%b out=%0d expected 1/6", ovld3, out3); end
    tick();
  endtask

  initial begin
    in1 = '0; in3 = '0; vld1 = '0; vld3 = '0; ordy1 = 1'b1; ordy3 = 1'b1;
    test_reset();
    test_basic();
    test_held();
    test_back_to_back();
    test_backpressure();
    test_accumulate();
    test_random_stream();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time %0t expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/add_acc_n.md
ADD_ACC_N -- requirements
Module: add_acc_n

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (legal 8..64).
REQ-002 Parameter NUM_IN, default 4, number of operand channels (legal 2..8).
REQ-003 Parameter ACC_LEN, default 1, joined operand sets summed per result (legal 1..256).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 add__in  input  NUM_IN*WIDTH  operands, channel i at bits [i*WIDTH +: WIDTH].
REQ-007 add__in_vld  input  NUM_IN  per-channel operand valid.
REQ-008 add__in_rdy  output  NUM_IN  per-channel operand accept strobe.
REQ-009 add__out0  output  WIDTH  result.
REQ-010 add__out0_vld  output  1  result valid.
REQ-011 add__out0_rdy  input  1  result consumer ready.
REQ-012 add__out0_ovf  output  1  result overflowed/saturated, qualified by add__out0_vld.

Function
REQ-013 Each channel SHALL own one operand register plus valid bit; load_en[i] = add__in_vld[i] & (~valid[i] | fire).
REQ-014 add__in_rdy[i] SHALL equal load_en[i] (transfer occurs in the cycle it is asserted; rdy may depend on vld).
REQ-015 An operand register whose vld is low while load is permitted SHALL clear its valid bit.
REQ-016 out_free SHALL be ~out_valid | add__out0_rdy.
REQ-017 fire SHALL be (AND of all channel valid bits) & (cnt != ACC_LEN-1 | out_free).
REQ-018 On fire the sum of all NUM_IN registered operands SHALL be added to acc; if cnt != ACC_LEN-1 then acc <= acc+sum and cnt <= cnt+1.
REQ-019 On fire with cnt == ACC_LEN-1 the output register SHALL load acc+sum, out_valid SHALL set, acc SHALL clear, cnt SHALL clear.
REQ-020 When out_valid & add__out0_rdy and no terminal fire occurs, out_valid SHALL clear next cycle.
REQ-021 Terminal fire and output drain in the same cycle SHALL leave out_valid set with the new result (full throughput).
REQ-022 With ACC_LEN=1, latency from operand transfer to add__out0_vld SHALL be 2 cycles; sustained throughput one result per cycle.
REQ-023 Channels arriving on different cycles SHALL be held; no channel is consumed until all are valid.
REQ-024 Internal acc and sum SHALL be held at WIDTH+clog2(NUM_IN*ACC_LEN)+1 bits signed; no intermediate loss.
REQ-025 Output register and add__out0_ovf SHALL hold while out_valid & ~add__out0_rdy.

Reset
REQ-026 rst low SHALL immediately clear all valid bits, operand registers, acc, cnt, add__out0, add__out0_vld, add__out0_ovf to 0.
REQ-027 During rst low add__in_rdy SHALL be 0; reset mid-accumulation SHALL discard partial acc.
REQ-028 First operand accept possible in first clock edge after rst deasserts.

Configuration
REQ-029 Macro ADD_ACC_SAT_EN defined: final result SHALL clamp signed to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; add__out0_ovf=1 when clamping applied.
REQ-030 Macro ADD_ACC_SAT_EN undefined: result SHALL be low WIDTH bits (modular wrap); add__out0_ovf tied 0.

Verification
REQ-031 WIDTH=32,NUM_IN=4,ACC_LEN=1; operands 1,2,3,4 all vld cycle 0, out_rdy=1 -> add__out0=10, vld cycle 2, all rdy high cycle 0.
REQ-032 ch0..2 vld cycle 0, ch3 vld cycle 5 -> no result until cycle 7; ch0..2 rdy low cycles 1..5 while held.
REQ-033 ACC_LEN=3, sets {1,1,1,1} x3 back-to-back, out_rdy=1 -> single result 12, vld 2 cycles after third set.
REQ-034 out_rdy=0 with result pending, new full set arriving -> set latched in operand regs, next set stalled (rdy=0), no result lost; out_rdy=1 -> results in order.
REQ-035 ADD_ACC_SAT_EN, WIDTH=8, operands 100,100,0,0 -> out 127, ovf=1; without macro -> out 0xC8, ovf=0.
REQ-036 rst low during cnt=1 of ACC_LEN=3 -> all outputs 0 immediately; next 3 sets {2,0,0,0} -> result 6.
